// File: rtl/power_avg_sequencer.sv
// Power-sample window accumulator that hands each completed window sum/count to an
// external division32 unit and publishes the resulting average.
module power_avg_sequencer #(
    parameter int unsigned SAMPLE_W = 16,
    parameter int unsigned CNT_W    = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                sample_valid,
    input  logic [SAMPLE_W-1:0] sample,
    input  logic [CNT_W-1:0]    win_len,
    output logic                div_go,
    output logic [31:0]         div_dividend,
    output logic [31:0]         div_divisor,
    input  logic                div_done,
    input  logic [31:0]         div_quotient,
    output logic [31:0]         avg,
    output logic                avg_valid,
    output logic                busy,
    output logic                overrun
);
    typedef enum logic [1:0] {D_IDLE, D_GO, D_WAIT} state_t;

    state_t           state;
    logic [31:0]      acc_sum;
    logic [CNT_W-1:0] acc_cnt;
    logic [CNT_W-1:0] win_reg;
    logic             done_q;

    logic [CNT_W-1:0] win_eff;
    logic [CNT_W-1:0] cnt_next;
    logic [31:0]      sum_next;
    logic             win_done;
    logic             done_rise;

    // The first sample of a window must be compared against the length being latched
    // in the same cycle, otherwise a one-sample window could never complete.
    always_comb begin
        win_eff = win_reg;
        if (acc_cnt == '0) begin
            win_eff = (win_len == '0) ? CNT_W'(1) : win_len;
        end
        cnt_next  = acc_cnt + CNT_W'(1);
        sum_next  = acc_sum + 32'(sample);
        win_done  = sample_valid && (cnt_next == win_eff);
        done_rise = div_done && !done_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= D_IDLE;
            acc_sum      <= '0;
            acc_cnt      <= '0;
            win_reg      <= '0;
            done_q       <= 1'b0;
            div_go       <= 1'b0;
            div_dividend <= '0;
            div_divisor  <= '0;
            avg          <= '0;
            avg_valid    <= 1'b0;
            busy         <= 1'b0;
            overrun      <= 1'b0;
        end else begin
            done_q    <= div_done;
            div_go    <= 1'b0;
            avg_valid <= 1'b0;

            if (sample_valid) begin
                if (acc_cnt == '0) begin
                    win_reg <= win_eff;
                end
                if (win_done) begin
                    acc_sum <= '0;
                    acc_cnt <= '0;
                    if (state == D_IDLE) begin
                        div_dividend <= sum_next;
                        div_divisor  <= 32'(cnt_next);
                        div_go       <= 1'b1;
                        busy         <= 1'b1;
                        state        <= D_GO;
                    end else begin
                        overrun <= 1'b1;
                    end
                end else begin
                    acc_sum <= sum_next;
                    acc_cnt <= cnt_next;
                end
            end

            // A window completing in D_WAIT was already dropped above using the current
            // state, so a coincident done rise still retires the outstanding division.
            case (state)
                D_GO: state <= D_WAIT;
                D_WAIT: begin
                    if (done_rise) begin
                        avg       <= div_quotient;
                        avg_valid <= 1'b1;
                        busy      <= 1'b0;
                        state     <= D_IDLE;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
